// File: rtl/opcodes_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// opcodes_pkg : funct3 encodings for loads and stores            rev 1.0
// ---------------------------------------------------------------------------
package opcodes_pkg;

  localparam logic [2:0] c_FUNCT3_LB  = 3'b000;
  localparam logic [2:0] c_FUNCT3_LH  = 3'b001;
  localparam logic [2:0] c_FUNCT3_LW  = 3'b010;
  localparam logic [2:0] c_FUNCT3_LBU = 3'b100;
  localparam logic [2:0] c_FUNCT3_LHU = 3'b101;
  localparam logic [2:0] c_FUNCT3_SB  = 3'b000;
  localparam logic [2:0] c_FUNCT3_SH  = 3'b001;
  localparam logic [2:0] c_FUNCT3_SW  = 3'b010;

endpackage
`default_nettype wire

// File: rtl/virgule_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// virgule_pkg : core types plus byte-lane strobe and load-extend helpers rev 1.0
// ---------------------------------------------------------------------------
package virgule_pkg;
  import opcodes_pkg::*;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic [2:0] funct3;
    word_t      imm;
    logic       has_rd;
    logic [4:0] rd;
  } instruction_t;

  localparam instruction_t instr_nop = '0;

  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} size_t;

  // Anything that is not a recognised byte or halfword encoding is a word.
  function automatic size_t access_size(input logic is_load, input logic [2:0] funct3);
    size_t s;
    s = SIZE_WORD;
    if (is_load) begin
      case (funct3)
        c_FUNCT3_LB, c_FUNCT3_LBU: s = SIZE_BYTE;
        c_FUNCT3_LH, c_FUNCT3_LHU: s = SIZE_HALF;
        default:                   s = SIZE_WORD;
      endcase
    end else begin
      case (funct3)
        c_FUNCT3_SB: s = SIZE_BYTE;
        c_FUNCT3_SH: s = SIZE_HALF;
        default:     s = SIZE_WORD;
      endcase
    end
    return s;
  endfunction

  function automatic logic [3:0] byte_strobe(input size_t size, input logic [1:0] offset);
    logic [3:0] s;
    case (size)
      SIZE_BYTE: s = 4'b0001 << offset;
      SIZE_HALF: s = 4'b0011 << offset;
      default:   s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic word_t load_extend(input logic [2:0] funct3, input word_t data);
    word_t v;
    case (funct3)
      c_FUNCT3_LB:  v = {{24{data[7]}}, data[7:0]};
      c_FUNCT3_LH:  v = {{16{data[15]}}, data[15:0]};
      c_FUNCT3_LBU: v = {24'b0, data[7:0]};
      c_FUNCT3_LHU: v = {16'b0, data[15:0]};
      default:      v = data;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_align : alignment check, byte lanes, store replication, load extend
// rev 1.0
// ---------------------------------------------------------------------------
module load_store_align
  import virgule_pkg::*;
#(
  parameter bit check_alignment = 1'b1
) (
  input  logic       is_load_i,
  input  logic [2:0] funct3_i,
  input  word_t      address_i,
  input  word_t      xs2_i,
  input  word_t      rdata_i,
  output word_t      address_o,
  output logic [3:0] wstrobe_o,
  output word_t      wdata_o,
  output word_t      load_o,
  output logic       misaligned_o
);

  size_t      w_size;
  logic       w_aligned;
  logic [1:0] w_offset;

  assign w_size = access_size(is_load_i, funct3_i);

  always_comb begin
    w_aligned = 1'b1;
    case (w_size)
      SIZE_HALF: w_aligned = ~address_i[0];
      SIZE_WORD: w_aligned = (address_i[1:0] == 2'b00);
      default:   w_aligned = 1'b1;
    endcase
  end

  generate
    if (check_alignment) begin : g_trap
      assign address_o    = address_i;
      assign misaligned_o = ~w_aligned;
    end else begin : g_force
      // Without trapping, the low bits the access width cannot use are dropped.
      assign misaligned_o = 1'b0;
      always_comb begin
        address_o = address_i;
        case (w_size)
          SIZE_HALF: address_o[0]   = 1'b0;
          SIZE_WORD: address_o[1:0] = 2'b00;
          default:   address_o      = address_i;
        endcase
      end
    end
  endgenerate

  assign w_offset  = address_o[1:0];
  assign wstrobe_o = is_load_i ? 4'b0000 : byte_strobe(w_size, w_offset);

  always_comb begin
    case (w_size)
      SIZE_BYTE: wdata_o = {4{xs2_i[7:0]}};
      SIZE_HALF: wdata_o = {2{xs2_i[15:0]}};
      default:   wdata_o = xs2_i;
    endcase
  end

  assign load_o = load_extend(funct3_i, rdata_i >> {w_offset, 3'b000});

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_unit : IDLE/REQUEST/DONE bus master for loads and stores  rev 1.0
// ---------------------------------------------------------------------------
module load_store_unit
  import virgule_pkg::*;
#(
  parameter bit check_alignment = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  instruction_t instr,
  input  word_t        xs1,
  input  word_t        xs2,
  output logic         busy,
  output logic         done,
  output logic         misaligned,
  output instruction_t dest_instr,
  output word_t        xd,
  output logic         enable,
  output logic         valid,
  input  logic         ready,
  output word_t        address,
  output logic [3:0]   wstrobe,
  output word_t        wdata,
  input  word_t        rdata
);

  typedef enum logic [1:0] {IDLE, REQUEST, DONE} state_t;

  state_t       state_q;
  logic         busy_q;
  logic         done_q;
  logic         misaligned_q;
  logic         enable_q;
  logic         valid_q;
  word_t        address_q;
  logic [3:0]   wstrobe_q;
  word_t        wdata_q;
  word_t        xd_q;
  instruction_t dest_q;

  logic       w_idle;
  logic       w_accept;
  word_t      w_address_sum;
  logic       w_sel_load;
  logic [2:0] w_sel_funct3;
  word_t      w_sel_address;
  word_t      w_address;
  logic [3:0] w_wstrobe;
  word_t      w_wdata;
  word_t      w_load;
  logic       w_misaligned;

  assign w_idle        = (state_q == IDLE);
  assign w_accept      = w_idle && start && (instr.is_load || instr.is_store);
  assign w_address_sum = xs1 + instr.imm;

  // The aligner serves the incoming instruction in IDLE and the captured one afterwards.
  assign w_sel_load    = w_idle ? instr.is_load : dest_q.is_load;
  assign w_sel_funct3  = w_idle ? instr.funct3  : dest_q.funct3;
  assign w_sel_address = w_idle ? w_address_sum : address_q;

  load_store_align #(
    .check_alignment(check_alignment)
  ) u_align (
    .is_load_i   (w_sel_load),
    .funct3_i    (w_sel_funct3),
    .address_i   (w_sel_address),
    .xs2_i       (xs2),
    .rdata_i     (rdata),
    .address_o   (w_address),
    .wstrobe_o   (w_wstrobe),
    .wdata_o     (w_wdata),
    .load_o      (w_load),
    .misaligned_o(w_misaligned)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      enable_q     <= 1'b0;
      valid_q      <= 1'b0;
      address_q    <= '0;
      wstrobe_q    <= '0;
      wdata_q      <= '0;
      xd_q         <= '0;
      dest_q       <= instr_nop;
    end else begin
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      enable_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            dest_q    <= instr;
            address_q <= w_address;
            wstrobe_q <= w_wstrobe;
            wdata_q   <= w_wdata;
            busy_q    <= 1'b1;
            if (w_misaligned) begin
              state_q      <= DONE;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
            end else begin
              state_q <= REQUEST;
              valid_q <= 1'b1;
            end
          end
        end
        REQUEST: begin
          if (ready) begin
            valid_q  <= 1'b0;
            xd_q     <= w_load;
            done_q   <= 1'b1;
            enable_q <= dest_q.is_load & dest_q.has_rd;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign misaligned = misaligned_q;
  assign enable     = enable_q;
  assign valid      = valid_q;
  assign address    = address_q;
  assign wstrobe    = wstrobe_q;
  assign wdata      = wdata_q;
  assign xd         = xd_q;
  assign dest_instr = dest_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_load_store_unit : transaction-level model checked every cycle against a
// trapping and a force-aligned instance                              rev 1.0
// ---------------------------------------------------------------------------
module tb_load_store_unit;
  import virgule_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         ready = 1'b0;
  instruction_t instr = instr_nop;
  word_t        xs1 = '0;
  word_t        xs2 = '0;
  word_t        rdata = '0;

  logic [1:0]   busy_w, done_w, mis_w, en_w, valid_w;
  instruction_t dest_w [2];
  word_t        xd_w [2];
  word_t        addr_w [2];
  word_t        wdata_w [2];
  logic [3:0]   strb_w [2];

  int checks = 0;
  int errors = 0;
  bit run_checks = 1'b0;
  int en_count [2] = '{0, 0};
  int done_count [2] = '{0, 0};

  always #5 clk = ~clk;

  load_store_unit #(.check_alignment(1'b1)) dut_trap (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .xs1(xs1), .xs2(xs2),
    .busy(busy_w[0]), .done(done_w[0]), .misaligned(mis_w[0]), .dest_instr(dest_w[0]),
    .xd(xd_w[0]), .enable(en_w[0]), .valid(valid_w[0]), .ready(ready),
    .address(addr_w[0]), .wstrobe(strb_w[0]), .wdata(wdata_w[0]), .rdata(rdata)
  );

  load_store_unit #(.check_alignment(1'b0)) dut_force (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .xs1(xs1), .xs2(xs2),
    .busy(busy_w[1]), .done(done_w[1]), .misaligned(mis_w[1]), .dest_instr(dest_w[1]),
    .xd(xd_w[1]), .enable(en_w[1]), .valid(valid_w[1]), .ready(ready),
    .address(addr_w[1]), .wstrobe(strb_w[1]), .wdata(wdata_w[1]), .rdata(rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit         trap;
    bit         load;
    bit         has_rd;
    bit         sgn;
    int         nbytes;
    word_t      addr;
    logic [3:0] strb;
    word_t      wdata;
  } txn_t;

  function automatic txn_t plan(input instruction_t in, input word_t a, input word_t b, input bit ca);
    txn_t  t;
    word_t addr;
    int    n;
    logic [7:0] s;
    if (in.is_load)
      n = (in.funct3 == 3'd0 || in.funct3 == 3'd4) ? 1 : (in.funct3 == 3'd1 || in.funct3 == 3'd5) ? 2 : 4;
    else
      n = (in.funct3 == 3'd0) ? 1 : (in.funct3 == 3'd1) ? 2 : 4;
    addr = a + in.imm;
    t.trap = ca && ((addr & word_t'(n - 1)) != 0);
    if (!ca) addr = addr & ~word_t'(n - 1);
    t.addr   = addr;
    t.nbytes = n;
    t.load   = in.is_load;
    t.has_rd = in.has_rd;
    t.sgn    = in.is_load && (in.funct3 == 3'd0 || in.funct3 == 3'd1);
    s = 8'((1 << n) - 1) << addr[1:0];
    t.strb = in.is_load ? 4'b0000 : s[3:0];
    for (int i = 0; i < 4; i++) t.wdata[8*i +: 8] = b[8*(i % n) +: 8];
    return t;
  endfunction

  function automatic word_t load_val(input txn_t t, input word_t rd);
    longint v, mask;
    v    = longint'(rd >> (8 * t.addr[1:0]));
    mask = (longint'(1) << (8 * t.nbytes)) - 1;
    v    = v & mask;
    if (t.sgn && (((v >> (8 * t.nbytes - 1)) & 1) == 1)) v = v | ~mask;
    return word_t'(v);
  endfunction

  function automatic int accept_phase(input instruction_t in, input word_t a, input word_t b, input bit ca);
    txn_t t;
    t = plan(in, a, b, ca);
    return t.trap ? 2 : 1;
  endfunction

  // phase: 0 idle, 1 waiting on the bus, 2 completion cycle
  int           ph [2] = '{0, 0};
  txn_t         cur [2];
  instruction_t m_dest [2];
  word_t        m_xd [2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        ph[i]     <= 0;
        m_dest[i] <= instr_nop;
        m_xd[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (ph[i])
          0: if (start && (instr.is_load || instr.is_store)) begin
               cur[i]    <= plan(instr, xs1, xs2, i == 0);
               m_dest[i] <= instr;
               ph[i]     <= accept_phase(instr, xs1, xs2, i == 0);
             end
          1: if (ready) begin
               if (cur[i].load) m_xd[i] <= load_val(cur[i], rdata);
               ph[i] <= 2;
             end
          default: ph[i] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (run_checks) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("valid[%0d]", i), valid_w[i], ph[i] == 1);
        chk($sformatf("busy[%0d]", i), busy_w[i], ph[i] != 0);
        chk($sformatf("done[%0d]", i), done_w[i], ph[i] == 2);
        chk($sformatf("misaligned[%0d]", i), mis_w[i], ph[i] == 2 && cur[i].trap);
        chk($sformatf("enable[%0d]", i), en_w[i],
            ph[i] == 2 && !cur[i].trap && cur[i].load && cur[i].has_rd);
        chk($sformatf("dest_instr[%0d]", i), dest_w[i], m_dest[i]);
        if (!reset) begin
          chk($sformatf("rst_address[%0d]", i), addr_w[i], 0);
          chk($sformatf("rst_wstrobe[%0d]", i), strb_w[i], 0);
          chk($sformatf("rst_wdata[%0d]", i), wdata_w[i], 0);
          chk($sformatf("rst_xd[%0d]", i), xd_w[i], 0);
        end else if (ph[i] == 1) begin
          chk($sformatf("address[%0d]", i), addr_w[i], cur[i].addr);
          chk($sformatf("wstrobe[%0d]", i), strb_w[i], cur[i].strb);
          chk($sformatf("wdata[%0d]", i), wdata_w[i], cur[i].wdata);
        end
        if (reset && ph[i] == 2 && cur[i].load && !cur[i].trap)
          chk($sformatf("xd[%0d]", i), xd_w[i], m_xd[i]);
        if (en_w[i]) en_count[i]++;
        if (done_w[i]) done_count[i]++;
      end
    end
  end

  // ---------------- directed helpers ----------------
  typedef struct {
    int         lat;
    bit         v1;
    word_t      a1;
    logic [3:0] s1;
    word_t      d1;
    bit         b_v1;
    word_t      b_a1;
    word_t      xd;
    bit         en;
    bit         mis;
    logic [4:0] rd;
  } res_t;

  function automatic instruction_t mk(input bit ld, input bit st, input logic [2:0] f3,
                                      input word_t imm, input bit hrd, input logic [4:0] rd);
    instruction_t t;
    t.is_load = ld; t.is_store = st; t.funct3 = f3; t.imm = imm; t.has_rd = hrd; t.rd = rd;
    return t;
  endfunction

  task automatic run_op(input instruction_t in, input word_t a, input word_t b, input int waits,
                        input word_t rd, input bit poke, input instruction_t poke_in, output res_t r);
    start = 1'b1; instr = in; xs1 = a; xs2 = b; rdata = rd; ready = (waits == 0);
    r = '{default: 0};
    @(posedge clk); #1;
    start = 1'b0;
    r.lat = 1;
    r.v1 = valid_w[0]; r.a1 = addr_w[0]; r.s1 = strb_w[0]; r.d1 = wdata_w[0];
    r.b_v1 = valid_w[1]; r.b_a1 = addr_w[1];
    if (poke) begin
      start = 1'b1; instr = poke_in;
    end
    while (!done_w[0] && r.lat < 40) begin
      ready = (r.lat > waits);
      @(posedge clk); #1;
      start = 1'b0;
      r.lat++;
    end
    if (r.lat >= 40) begin
      checks++; errors++;
      $display("FAIL done_timeout: actual=no_done expected=done_within_40");
    end
    r.xd = xd_w[0]; r.en = en_w[0]; r.mis = mis_w[0]; r.rd = dest_w[0].rd;
    start = 1'b0; ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  initial begin
    res_t r;
    int   e0, d0;
    #1 reset = 1'b0;
    #2 run_checks = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid_w, 0);
    chk("rst_done", done_w, 0);
    chk("rst_enable", en_w, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(mk(0, 1, 3'd2, 32'd4, 0, 0), 32'h1000, 32'hDEADBEEF, 0, 0, 0, instr_nop, r);
    chk("sw_lat", r.lat, 2);
    chk("sw_valid", r.v1, 1);
    chk("sw_addr", r.a1, 32'h1004);
    chk("sw_strb", r.s1, 4'b1111);
    chk("sw_wdata", r.d1, 32'hDEADBEEF);
    chk("sw_enable", r.en, 0);

    run_op(mk(1, 0, 3'd0, 32'd3, 1, 5), 32'h1000, 0, 0, 32'h80FFFFFF, 0, instr_nop, r);
    chk("lb_xd", r.xd, 32'hFFFFFF80);
    chk("lb_enable", r.en, 1);
    chk("lb_rd", r.rd, 5);
    run_op(mk(1, 0, 3'd4, 32'd3, 1, 5), 32'h1000, 0, 0, 32'h80FFFFFF, 0, instr_nop, r);
    chk("lbu_xd", r.xd, 32'h00000080);

    run_op(mk(0, 1, 3'd1, 32'd2, 0, 0), 32'h2000, 32'h1234ABCD, 3, 0, 0, instr_nop, r);
    chk("sh_strb", r.s1, 4'b1100);
    chk("sh_wdata", r.d1, 32'hABCDABCD);
    chk("sh_lat", r.lat, 5);

    run_op(mk(1, 0, 3'd2, 32'd1, 1, 3), 32'h3000, 0, 0, 32'h12345678, 0, instr_nop, r);
    chk("lw_mis_valid", r.v1, 0);
    chk("lw_mis_lat", r.lat, 1);
    chk("lw_mis_flag", r.mis, 1);
    chk("lw_mis_enable", r.en, 0);
    chk("lw_force_valid", r.b_v1, 1);
    chk("lw_force_addr", r.b_a1, 32'h3000);

    start = 1'b1; instr = mk(1, 0, 3'd2, 32'd0, 1, 9); xs1 = 32'h4000; ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("midreq_valid", valid_w, 2'b11);
    reset = 1'b0;
    #1;
    chk("async_rst_valid", valid_w, 2'b00);
    chk("async_rst_busy", busy_w, 2'b00);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_op(mk(1, 0, 3'd2, 32'd0, 1, 9), 32'h4000, 0, 0, 32'h55AA55AA, 0, instr_nop, r);
    chk("post_rst_xd", r.xd, 32'h55AA55AA);

    e0 = en_count[0]; d0 = done_count[0];
    run_op(mk(0, 1, 3'd2, 32'd0, 0, 0), 32'h5000, 32'h0BADF00D, 1, 0, 1, mk(1, 0, 3'd2, 0, 1, 7), r);
    chk("busy_start_enables", en_count[0] - e0, 0);
    chk("busy_start_dones", done_count[0] - d0, 1);
    e0 = en_count[0];
    run_op(mk(1, 0, 3'd2, 32'd0, 0, 0), 32'h6000, 0, 0, 32'hCAFEF00D, 0, instr_nop, r);
    chk("no_rd_enable", en_count[0] - e0, 0);
    chk("no_rd_xd", r.xd, 32'hCAFEF00D);

    repeat (2000) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0:       begin instr.is_load = 1'b1; instr.is_store = 1'b0; end
        1:       begin instr.is_load = 1'b0; instr.is_store = 1'b1; end
        default: begin instr.is_load = 1'b0; instr.is_store = 1'b0; end
      endcase
      instr.funct3 = 3'($urandom_range(0, 7));
      instr.imm    = ($urandom_range(0, 1) == 0) ? word_t'($urandom_range(0, 15)) : $urandom;
      instr.has_rd = 1'($urandom_range(0, 1));
      instr.rd     = 5'($urandom_range(0, 31));
      xs1   = $urandom;
      xs2   = $urandom;
      rdata = $urandom;
      ready = ($urandom_range(0, 1) == 1);
    end
    reset = 1'b1; start = 1'b0; ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: check_alignment, default 1, 1 = misaligned accesses are trapped, 0 = low address bits are ignored (forced aligned).
REQ-002 One clock; reset is asynchronous and active-low. Ports clk and reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request to execute instr; sampled only in IDLE.
REQ-006 instr  in  instruction_t  decoded instruction (is_load, is_store, funct3, imm, has_rd, rd).
REQ-007 xs1, xs2  in  word_t  operands read from register_unit.
REQ-008 busy  out  1  high in REQUEST and DONE.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 misaligned  out  1  one-cycle pulse with done on a trapped access.
REQ-011 dest_instr  out  instruction_t  captured instr, drives register_unit dest_instr.
REQ-012 xd  out  word_t  extended load data, drives register_unit xd.
REQ-013 enable  out  1  register_unit write strobe.
REQ-014 valid  out  1, ready  in  1, address  out  word_t, wstrobe  out  4, wdata  out  word_t, rdata  in  word_t  memory bus.

Function
REQ-015 FSM states: IDLE, REQUEST, DONE; all outputs registered.
REQ-016 IDLE: start=1 with is_load or is_store captures instr, address=xs1+imm (mod 2^32), store data; moves to REQUEST; start otherwise is ignored.
REQ-017 Alignment: LH/LHU/SH need address[0]=0; LW/SW need address[1:0]=0; bytes are always aligned.
REQ-018 Misaligned with check_alignment=1: no bus access; IDLE->DONE with misaligned=1, enable=0.
REQ-019 REQUEST: valid=1, address/wstrobe/wdata held stable until ready=1; on ready=1 capture rdata, go to DONE, valid=0 next cycle.
REQ-020 wstrobe: SB 0001<<address[1:0]; SH 0011<<address[1:0]; SW 1111; loads 0000.
REQ-021 wdata: SB {4{xs2[7:0]}}; SH {2{xs2[15:0]}}; SW xs2.
REQ-022 Load data: rdata >> (8*address[1:0]), then LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-023 DONE: done=1 for one cycle; enable=1 only for a non-trapped load with has_rd=1; xd valid while done=1; then IDLE.
REQ-024 Latency: start at cycle N with ready tied high gives valid at N+1 and done at N+2; each ready wait cycle adds one.
REQ-025 start while busy is ignored; no queuing.
REQ-026 Unknown funct3: treated as word width.

Reset
REQ-027 reset=0 immediately forces IDLE, valid=0, done=0, misaligned=0, enable=0, wstrobe=0, address=0, wdata=0, xd=0, dest_instr=instr_nop, including mid-REQUEST.
REQ-028 After reset release, the first accepted start behaves as from power-up.

Structure
REQ-029 Load/store funct3 constants in opcodes_pkg; byte-lane strobe and extend functions in virgule_pkg; FSM state enum local.
REQ-030 One combinational sub-module, load_store_align: funct3 + address + xs2/rdata -> wstrobe, wdata, extended load value, misaligned flag.

Verification
REQ-031 SW xs1=0x1000, imm=4, xs2=0xDEADBEEF, ready=1 -> address 0x1004, wstrobe 1111, wdata 0xDEADBEEF, done at N+2, enable=0.
REQ-032 LB address 0x1003, rdata 0x80FFFFFF, rd=5 -> xd=0xFFFFFF80, enable=1, dest_instr.rd=5; LBU same -> xd=0x00000080.
REQ-033 SH address 0x2002, xs2=0x1234ABCD -> wstrobe 1100, wdata 0xABCDABCD; ready held low 3 cycles -> signals stable, done at N+5.
REQ-034 LW address 0x3001 -> no valid, done+misaligned at N+1, enable=0; with check_alignment=0 -> bus address 0x3000.
REQ-035 Assert reset=0 mid-REQUEST -> valid=0 immediately; next LW with rdata 0x55AA55AA -> xd=0x55AA55AA.
REQ-036 Second start while busy and LW to rd=0 (has_rd=0) -> neither causes a write (enable stays 0 for both).
